systolic_mm_engine: RTL and testbench
=====================================

// Module: systolic_mm_engine
// PURPOSE
//  Self-sequencing, parametrised output-stationary systolic matrix engine: C[RxC] = A[RxK] x B[KxC], K set per job.
//  Generalises the fixed 4x4 PE array with on-chip input skewing, valid/ready stream handshakes and a job FSM.
//  Also adds a row-serial result drain and optional saturating accumulation.
//  Sits between the operand buffers and the result writeback path.
// PARAMETERS
//  ROWS        4   PE rows = rows of A and C
//  COLS        4   PE columns = columns of B and C
//  DATA_WIDTH  8   signed operand width
//  ACC_WIDTH   32  signed accumulator width (>= 2*DATA_WIDTH)
//  K_WIDTH     16  width of k_len
//  SATURATE    0   1: saturating accumulate; 0: two's-complement wrap
// PORTS
//  clk        in   1                  clock, all logic on rising edge
//  rst        in   1                  synchronous reset, active-high
//  start      in   1                  job request, sampled only in IDLE
//  k_len      in   K_WIDTH            inner dimension K, sampled with start
//  in_valid   in   1                  operand beat valid
//  in_ready   out  1                  operand beat accepted when in_valid & in_ready
//  in_a       in   ROWS*DATA_WIDTH    column k of A; element i at [i*DATA_WIDTH +: DATA_WIDTH]
//  in_b       in   COLS*DATA_WIDTH    row k of B; element j at [j*DATA_WIDTH +: DATA_WIDTH]
//  out_valid  out  1                  result row valid
//  out_ready  in   1                  result row consumed when out_valid & out_ready
//  out_row    out  COLS*ACC_WIDTH     row r of C; element j at [j*ACC_WIDTH +: ACC_WIDTH]
//  out_idx    out  $clog2(ROWS)       row index r of out_row
//  busy       out  1                  high in any state other than IDLE
//  done       out  1                  one-cycle pulse after the last row handshake
// BEHAVIOUR
//  Reset: state=IDLE; all accumulators, skew registers and PE pipeline registers are 0.
//   All outputs are 0; in_ready=0.
//  FSM: IDLE -> STREAM -> FLUSH -> DRAIN -> IDLE.
//  IDLE: start=1 latches k_len, clears every accumulator and skew register, and enters STREAM.
//   If k_len=0, the FSM goes directly to DRAIN with all accumulators at 0.
//  STREAM: in_ready=1. Each accepted beat advances the whole array one step (global enable).
//   Cycles with no accepted beat freeze the array, skew chain and counters completely.
//   After the K-th accepted beat, the FSM goes to FLUSH.
//  Skew: in_a[i] is delayed i enabled steps before entering row i. in_b[j] is delayed j steps before entering column j.
//   PE(i,j) therefore multiplies A[i][k]*B[k][j] at enabled step k+i+j.
//  FLUSH: in_ready=0. The array is enabled every cycle, with zeros injected at the skew inputs.
//   FLUSH lasts exactly ROWS+COLS-1 cycles; at its end every C[i][j] is final. Then DRAIN.
//  DRAIN: out_valid=1, out_idx=r, out_row=C[r][*], with r starting at 0.
//   r advances on each handshake. out_row/out_idx hold stable while out_ready=0.
//   The handshake for r=ROWS-1 returns the FSM to IDLE and pulses done=1 on the next cycle.
//  Arithmetic: product is signed 2*DATA_WIDTH bits, sign-extended to ACC_WIDTH.
//   SATURATE=1: on overflow, sum clamps to +(2^(ACC_WIDTH-1)-1) or -2^(ACC_WIDTH-1), and accumulation continues from the clamp.
//  Latency: start accept -> first out_valid = K + ROWS+COLS-1 + 1 cycles, with no stalls.
//  start while busy is ignored. in_valid outside STREAM is ignored (not accepted).
//  Accumulators keep the last job's C until the next start; they are not cleared on done.
//  rst asserted mid-job (any state) aborts the job. Next cycle is IDLE with the reset values; no done pulse.
// TESTING
//  T1 ROWS=COLS=4, K=4, A=I, B=1..16 row-major, no stalls -> rows {1,2,3,4}..{13,14,15,16}.
//   first out_valid exactly 12 cycles after start; done 1 cycle after row 3 handshake.
//  T2 same data with in_valid toggled 1010.. and out_ready low 3 cycles per row.
//   -> identical C; out_row stable while stalled; no beat lost or duplicated.
//  T3 DW=8, ACC=16, K=3, all operands -128 (product 16384).
//   -> SATURATE=1 gives 32767 everywhere; SATURATE=0 gives -16384 everywhere.
//  T4 k_len=0 -> DRAIN entered 1 cycle after start; 4 rows of zeros; done pulses.
//  T5 rst pulsed for 1 cycle after the 2nd beat of K=4.
//   -> IDLE, outputs 0, no done; a fresh job then produces correct C.
//  T6 start held high during DRAIN -> ignored; a single job completes; k_len change has no effect.

Source files
------------

// File: rtl/systolic_mm_engine.sv
// rtl/systolic_mm_engine.sv - output-stationary systolic matrix engine with skewed operand streams and row drain
module systolic_mm_engine #(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 32,
    parameter int K_WIDTH    = 16,
    parameter int SATURATE   = 0,
    localparam int IDX_W     = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [K_WIDTH-1:0]            k_len,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [ROWS*DATA_WIDTH-1:0]    in_a,
    input  logic [COLS*DATA_WIDTH-1:0]    in_b,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [COLS*ACC_WIDTH-1:0]     out_row,
    output logic [IDX_W-1:0]              out_idx,
    output logic                          busy,
    output logic                          done
);
    localparam int FL_W = $clog2(ROWS + COLS);
    localparam logic [FL_W-1:0]    FLUSH_LAST = FL_W'(ROWS + COLS - 2);
    localparam logic [IDX_W-1:0]   ROW_LAST   = IDX_W'(ROWS - 1);
    localparam logic [K_WIDTH-1:0] K_ONE      = K_WIDTH'(1);

    typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DRAIN} state_t;

    state_t               state;
    logic [K_WIDTH-1:0]   k_reg;
    logic [K_WIDTH-1:0]   beat_cnt;
    logic [FL_W-1:0]      flush_cnt;
    logic [IDX_W-1:0]     row_idx;

    logic                 step_en;
    logic                 clear;

    logic signed [DATA_WIDTH-1:0] a_src [ROWS];
    logic signed [DATA_WIDTH-1:0] b_src [COLS];
    logic signed [DATA_WIDTH-1:0] sk_a  [ROWS][ROWS];
    logic signed [DATA_WIDTH-1:0] sk_b  [COLS][COLS];
    logic signed [DATA_WIDTH-1:0] row_a [ROWS];
    logic signed [DATA_WIDTH-1:0] col_b [COLS];
    logic signed [DATA_WIDTH-1:0] a_pe  [ROWS][COLS];
    logic signed [DATA_WIDTH-1:0] b_pe  [ROWS][COLS];
    logic signed [DATA_WIDTH-1:0] a_reg [ROWS][COLS];
    logic signed [DATA_WIDTH-1:0] b_reg [ROWS][COLS];
    logic signed [ACC_WIDTH-1:0]  acc   [ROWS][COLS];

    // One accumulate step: exact signed product, then wrap or clamp on overflow
    function automatic logic signed [ACC_WIDTH-1:0] mac(
        input logic signed [ACC_WIDTH-1:0]  acc_in,
        input logic signed [DATA_WIDTH-1:0] a_in,
        input logic signed [DATA_WIDTH-1:0] b_in
    );
        logic [2*DATA_WIDTH-1:0] prod;
        logic [ACC_WIDTH:0]      sum;
        prod = {{DATA_WIDTH{a_in[DATA_WIDTH-1]}}, a_in} * {{DATA_WIDTH{b_in[DATA_WIDTH-1]}}, b_in};
        sum  = {acc_in[ACC_WIDTH-1], acc_in}
             + {{(ACC_WIDTH + 1 - 2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};
        if (SATURATE != 0 && (sum[ACC_WIDTH] != sum[ACC_WIDTH-1])) begin
            mac = sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        end else begin
            mac = sum[ACC_WIDTH-1:0];
        end
    endfunction

    assign in_ready  = (state == STREAM);
    assign out_valid = (state == DRAIN);
    assign busy      = (state != IDLE);
    assign out_idx   = row_idx;
    // The array moves only on accepted beats, then free-runs while flushing
    assign step_en   = ((state == STREAM) && in_valid) || (state == FLUSH);
    assign clear     = (state == IDLE) && start;

    // Operands enter the skew chains only while streaming; zeros are fed while flushing
    always_comb begin
        for (int i = 0; i < ROWS; i++) begin
            a_src[i] = (state == STREAM) ? in_a[i*DATA_WIDTH +: DATA_WIDTH] : '0;
        end
        for (int j = 0; j < COLS; j++) begin
            b_src[j] = (state == STREAM) ? in_b[j*DATA_WIDTH +: DATA_WIDTH] : '0;
        end
    end

    // Row i / column j taps after i / j delay stages; PE operands come from the left / upper neighbour
    for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
        if (gi == 0) begin : g_direct
            assign row_a[gi] = a_src[gi];
        end else begin : g_skewed
            assign row_a[gi] = sk_a[gi][gi-1];
        end
        for (genvar gj = 0; gj < COLS; gj++) begin : g_col
            if (gj == 0) begin : g_a_edge
                assign a_pe[gi][gj] = row_a[gi];
            end else begin : g_a_pass
                assign a_pe[gi][gj] = a_reg[gi][gj-1];
            end
            if (gi == 0) begin : g_b_edge
                assign b_pe[gi][gj] = col_b[gj];
            end else begin : g_b_pass
                assign b_pe[gi][gj] = b_reg[gi-1][gj];
            end
        end
    end

    for (genvar gj = 0; gj < COLS; gj++) begin : g_colsk
        if (gj == 0) begin : g_direct
            assign col_b[gj] = b_src[gj];
        end else begin : g_skewed
            assign col_b[gj] = sk_b[gj][gj-1];
        end
    end

    // Skew chains, operand pipelines and accumulators: cleared per job, advanced on step_en
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            for (int i = 0; i < ROWS; i++) begin
                for (int n = 0; n < ROWS; n++) sk_a[i][n] <= '0;
            end
            for (int j = 0; j < COLS; j++) begin
                for (int n = 0; n < COLS; n++) sk_b[j][n] <= '0;
            end
            for (int i = 0; i < ROWS; i++) begin
                for (int j = 0; j < COLS; j++) begin
                    a_reg[i][j] <= '0;
                    b_reg[i][j] <= '0;
                    acc[i][j]   <= '0;
                end
            end
        end else if (step_en) begin
            for (int i = 0; i < ROWS; i++) begin
                sk_a[i][0] <= a_src[i];
                for (int n = 1; n < ROWS; n++) sk_a[i][n] <= sk_a[i][n-1];
            end
            for (int j = 0; j < COLS; j++) begin
                sk_b[j][0] <= b_src[j];
                for (int n = 1; n < COLS; n++) sk_b[j][n] <= sk_b[j][n-1];
            end
            for (int i = 0; i < ROWS; i++) begin
                for (int j = 0; j < COLS; j++) begin
                    a_reg[i][j] <= a_pe[i][j];
                    b_reg[i][j] <= b_pe[i][j];
                    acc[i][j]   <= mac(acc[i][j], a_pe[i][j], b_pe[i][j]);
                end
            end
        end
    end

    // Result row selected by the drain index
    always_comb begin
        out_row = '0;
        for (int j = 0; j < COLS; j++) begin
            out_row[j*ACC_WIDTH +: ACC_WIDTH] = acc[row_idx][j];
        end
    end

    // Job sequencer: IDLE -> STREAM -> FLUSH -> DRAIN -> IDLE, done pulses after the final row
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            k_reg     <= '0;
            beat_cnt  <= '0;
            flush_cnt <= '0;
            row_idx   <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        k_reg     <= k_len;
                        beat_cnt  <= '0;
                        flush_cnt <= '0;
                        row_idx   <= '0;
                        state     <= (k_len == '0) ? DRAIN : STREAM;
                    end
                end
                STREAM: begin
                    if (in_valid) begin
                        beat_cnt <= beat_cnt + K_ONE;
                        if (beat_cnt + K_ONE == k_reg) begin
                            flush_cnt <= '0;
                            state     <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    flush_cnt <= flush_cnt + 1'b1;
                    if (flush_cnt == FLUSH_LAST) state <= DRAIN;
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (row_idx == ROW_LAST) begin
                            row_idx <= '0;
                            done    <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            row_idx <= row_idx + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_systolic_mm_engine.sv
// tb/tb_systolic_mm_engine.sv - directed testbench for systolic_mm_engine
module tb_systolic_mm_engine;
    logic         clk = 1'b0;
    logic         rst, start, in_valid, out_ready;
    logic [15:0]  k_len;
    logic [31:0]  in_a, in_b;

    logic         in_ready, out_valid, busy, done;
    logic [127:0] out_row;
    logic [1:0]   out_idx;

    logic         s_in_ready, s_out_valid, s_busy, s_done;
    logic [63:0]  s_out_row;
    logic [1:0]   s_out_idx;
    logic         w_in_ready, w_out_valid, w_busy, w_done;
    logic [63:0]  w_out_row;
    logic [1:0]   w_out_idx;

    int errors = 0;
    int checks = 0;
    int a_m[4][4];
    int b_m[4][4];
    logic [127:0] got_row[4];
    logic [63:0]  got_s[4];
    logic [63:0]  got_w[4];

    systolic_mm_engine dut (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row), .out_idx(out_idx),
        .busy(busy), .done(done)
    );

    systolic_mm_engine #(.ACC_WIDTH(16), .SATURATE(1)) dut_sat (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_row(s_out_row), .out_idx(s_out_idx),
        .busy(s_busy), .done(s_done)
    );

    systolic_mm_engine #(.ACC_WIDTH(16), .SATURATE(0)) dut_wrap (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len),
        .in_valid(in_valid), .in_ready(w_in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(w_out_valid), .out_ready(out_ready), .out_row(w_out_row), .out_idx(w_out_idx),
        .busy(w_busy), .done(w_done)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] model_row(input int r, input int k);
        logic [127:0] v;
        int s;
        v = '0;
        for (int j = 0; j < 4; j++) begin
            s = 0;
            for (int kk = 0; kk < k; kk++) s += a_m[r][kk] * b_m[kk][j];
            v[j*32 +: 32] = s;
        end
        return v;
    endfunction

    task automatic check_rows(input string name, input int k);
        logic [127:0] exp_row;
        for (int r = 0; r < 4; r++) begin
            exp_row = model_row(r, k);
            checks++;
            if (got_row[r] !== exp_row) begin
                errors++;
                $display("FAIL %s row%0d: got %h expected %h", name, r, got_row[r], exp_row);
            end
        end
    endtask

    // Runs one job starting just after a clock edge with the engine idle
    task automatic run_job(input string name, input int k, input bit toggle,
                           input int stall, input bit hold_start, output int lat);
        int beat = 0, rows = 0, cyc = 0, wait_cnt = 0;
        bit tog = 1'b1, fire_in, early = 1'b0, have_held = 1'b0;
        logic [127:0] held_row;
        logic [1:0]   held_idx;
        lat = -1;
        start = 1'b1; k_len = 16'(k); in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        cyc = 1;
        start = hold_start;
        if (hold_start) k_len = 16'd2;
        while (rows < 4 && cyc < 400) begin
            if (out_valid && lat < 0) lat = cyc;
            if (beat < k) begin
                in_valid = toggle ? tog : 1'b1;
                tog = ~tog;
                for (int i = 0; i < 4; i++) begin
                    in_a[i*8 +: 8] = a_m[i][beat][7:0];
                    in_b[i*8 +: 8] = b_m[beat][i][7:0];
                end
            end else begin
                in_valid = 1'b0;
            end
            fire_in = in_valid && in_ready;
            if (out_valid) begin
                if (have_held) begin
                    checks++;
                    if (out_row !== held_row || out_idx !== held_idx) begin
                        errors++;
                        $display("FAIL %s stall_hold: got %h/%0d required %h/%0d", name, out_row, out_idx, held_row, held_idx);
                    end
                end
                held_row = out_row; held_idx = out_idx; have_held = 1'b1;
                out_ready = (wait_cnt >= stall);
                if (out_ready) begin
                    checks++;
                    if (out_idx !== 2'(rows)) begin
                        errors++;
                        $display("FAIL %s out_idx: got %0d required %0d", name, out_idx, rows);
                    end
                    got_row[rows] = out_row;
                    got_s[rows] = s_out_row;
                    got_w[rows] = w_out_row;
                    rows++;
                    wait_cnt = 0;
                    have_held = 1'b0;
                    if (rows == 4) start = 1'b0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                out_ready = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
            if (fire_in) beat++;
            if (done && rows < 4) early = 1'b1;
        end
        in_valid = 1'b0; out_ready = 1'b0; start = 1'b0;
        checks++;
        if (rows != 4) begin
            errors++;
            $display("FAIL %s timeout: got %0d rows required 4", name, rows);
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s done_pulse: got done=%b busy=%b required 1/0", name, done, busy);
        end
        checks++;
        if (beat != k) begin
            errors++;
            $display("FAIL %s beats: got %0d required %0d", name, beat, k);
        end
        checks++;
        if (early) begin
            errors++;
            $display("FAIL %s early_done: got 1 required 0", name);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s done_clear: got done=%b busy=%b required 0/0", name, done, busy);
        end
    endtask

    task automatic load_t1();
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++) begin
                a_m[i][k] = (i == k) ? 1 : 0;
                b_m[i][k] = 4 * i + k + 1;
            end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0
            || out_row !== '0 || out_idx !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b in_ready=%b out_valid=%b done=%b row=%h idx=%0d required all 0",
                     busy, in_ready, out_valid, done, out_row, out_idx);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_identity();
        int lat;
        load_t1();
        run_job("t1", 4, 1'b0, 0, 1'b0, lat);
        check_rows("t1", 4);
        checks++;
        if (got_row[2] !== {32'd12, 32'd11, 32'd10, 32'd9}) begin
            errors++;
            $display("FAIL t1_row2_const: got %h required 12,11,10,9", got_row[2]);
        end
        checks++;
        if (lat != 12) begin
            errors++;
            $display("FAIL t1_latency: got %0d required 12", lat);
        end
    endtask

    task automatic test_stalls();
        int lat;
        load_t1();
        run_job("t2", 4, 1'b1, 3, 1'b0, lat);
        check_rows("t2", 4);
    endtask

    task automatic test_saturation();
        int lat;
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++) begin
                a_m[i][k] = -128;
                b_m[i][k] = -128;
            end
        run_job("t3", 3, 1'b0, 0, 1'b0, lat);
        check_rows("t3", 3);
        for (int r = 0; r < 4; r++) begin
            checks++;
            if (got_s[r] !== 64'h7FFF_7FFF_7FFF_7FFF) begin
                errors++;
                $display("FAIL t3_sat row%0d: got %h required 7fff x4", r, got_s[r]);
            end
            checks++;
            if (got_w[r] !== 64'hC000_C000_C000_C000) begin
                errors++;
                $display("FAIL t3_wrap row%0d: got %h required c000 x4", r, got_w[r]);
            end
        end
    endtask

    task automatic test_k_zero();
        int lat;
        run_job("t4", 0, 1'b0, 1, 1'b0, lat);
        check_rows("t4", 0);
        checks++;
        if (lat != 1) begin
            errors++;
            $display("FAIL t4_latency: got %0d required 1", lat);
        end
    endtask

    task automatic test_reset_mid_job();
        int lat;
        bit saw_done = 1'b0;
        load_t1();
        start = 1'b1; k_len = 16'd4;
        @(posedge clk); #1;
        start = 1'b0;
        in_valid = 1'b1;
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 4; i++) begin
                in_a[i*8 +: 8] = a_m[i][b][7:0];
                in_b[i*8 +: 8] = b_m[b][i][7:0];
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0
            || out_row !== '0 || out_idx !== 2'd0) begin
            errors++;
            $display("FAIL t5_abort: got busy=%b in_ready=%b out_valid=%b done=%b row=%h required all 0",
                     busy, in_ready, out_valid, done, out_row);
        end
        repeat (3) begin
            @(posedge clk); #1;
            if (done || busy) saw_done = 1'b1;
        end
        checks++;
        if (saw_done) begin
            errors++;
            $display("FAIL t5_quiet: got activity after abort required none");
        end
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++) begin
                a_m[i][k] = i + k - 2;
                b_m[k][i] = 3 * k - i;
            end
        run_job("t5", 4, 1'b0, 0, 1'b0, lat);
        check_rows("t5", 4);
    endtask

    task automatic test_start_held();
        int lat;
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++) begin
                a_m[i][k] = i - 2 * k + 1;
                b_m[k][i] = 5 - i * k;
            end
        run_job("t6", 4, 1'b0, 2, 1'b1, lat);
        check_rows("t6", 4);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; k_len = '0; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0;
        test_reset();
        test_identity();
        test_stalls();
        test_saturation();
        test_k_zero();
        test_reset_mid_job();
        test_start_held();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
